// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the operand muxes, the ALU and the writeback/PC-select stage.
// The master drives operands and consumer readiness; the slave (the ALU) returns the result side.
interface multicycle_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic [3:0]            Operation;
  logic                  InValid;
  logic                  InReady;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Branch;
  logic                  OutValid;
  logic                  OutReady;
  logic                  Busy;

  modport master (
    output SrcA, SrcB, Operation, InValid, OutReady,
    input  InReady, Result, Branch, OutValid, Busy
  );

  modport slave (
    input  SrcA, SrcB, Operation, InValid, OutReady,
    output InReady, Result, Branch, OutValid, Busy
  );
endinterface

// File: rtl/multicycle_alu.sv
// Execution ALU: single-cycle logic/arith/compare/branch, iterative 1-bit/cycle shifter.
// Result after 1 cycle (shifts: 1+shamt); holds result and blocks new requests until OutReady.
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  multicycle_alu_if.slave bus
);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [SW-1:0] CNT_ZERO = '0;
  localparam logic [SW-1:0] CNT_ONE  = SW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]         cnt_q, cnt_d;
  logic [1:0]            kind_q, kind_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  branch_q, branch_d;

  logic [DATA_WIDTH-1:0] sum, diff, alu_res, shifted;
  logic                  lt, alu_br, is_shift;
  logic [SW-1:0]         shamt;

  assign sum      = bus.SrcA + bus.SrcB;
  assign diff     = bus.SrcA - bus.SrcB;
  assign lt       = $signed(bus.SrcA) < $signed(bus.SrcB);
  assign shamt    = bus.SrcB[SW-1:0];
  assign is_shift = (bus.Operation == 4'b0100) || (bus.Operation == 4'b0101) ||
                    (bus.Operation == 4'b0111);

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (bus.Operation)
      4'b0000: alu_res = bus.SrcA & bus.SrcB;
      4'b0001: alu_res = bus.SrcA | bus.SrcB;
      4'b0010: alu_res = sum;
      4'b0011: alu_res = diff;
      4'b0110: alu_res = bus.SrcA ^ bus.SrcB;
      4'b1000: alu_br  = (bus.SrcA == bus.SrcB);
      4'b1001: begin
        alu_res = bus.SrcB;
        alu_br  = (bus.SrcA != bus.SrcB);
      end
      4'b1011: alu_br  = lt;
      4'b1100: alu_res = {{(DATA_WIDTH-1){1'b0}}, lt};
      4'b1101: alu_br  = ~lt;
      4'b1110: begin
        alu_res = sum;
        alu_br  = 1'b1;
      end
      4'b1111: begin
        alu_res = sum & ~{{(DATA_WIDTH-1){1'b0}}, 1'b1};
        alu_br  = 1'b1;
      end
      default: ;
    endcase
  end

  // kind_q holds Operation[1:0]: 00 SLL, 01 SRL, 11 SRA
  always_comb begin
    case (kind_q)
      2'b00:   shifted = {work_q[DATA_WIDTH-2:0], 1'b0};
      2'b01:   shifted = {1'b0, work_q[DATA_WIDTH-1:1]};
      default: shifted = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    result_d = result_q;
    branch_d = branch_q;
    case (state_q)
      IDLE: begin
        if (bus.InValid) begin
          if (is_shift) begin
            work_d = bus.SrcA;
            cnt_d  = shamt;
            kind_d = bus.Operation[1:0];
            if (shamt == CNT_ZERO) begin
              result_d = bus.SrcA;
              branch_d = 1'b0;
              state_d  = DONE;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            result_d = alu_res;
            branch_d = alu_br;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = shifted;
          branch_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      kind_q   <= 2'b00;
      result_q <= '0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      result_q <= result_d;
      branch_q <= branch_d;
    end
  end

  assign bus.InReady  = (state_q == IDLE);
  assign bus.OutValid = (state_q == DONE);
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Result   = result_q;
  assign bus.Branch   = branch_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed plus randomized bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multicycle_alu_if #(.DATA_WIDTH(32)) bus ();

  multicycle_alu #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the op table; lat = cycles from accept to OutValid
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic br, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = 32'h0;
    br  = 1'b0;
    lat = 1;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h3: r = a - b;
      4'h4: begin r = a << sh; lat = 1 + sh; end
      4'h5: begin r = a >> sh; lat = 1 + sh; end
      4'h6: r = a ^ b;
      4'h7: begin r = $signed(a) >>> sh; lat = 1 + sh; end
      4'h8: br = (a == b);
      4'h9: begin r = b; br = (a != b); end
      4'hB: br = ($signed(a) < $signed(b));
      4'hC: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hD: br = ($signed(a) >= $signed(b));
      4'hE: begin r = a + b; br = 1'b1; end
      4'hF: begin r = (a + b) & 32'hFFFF_FFFE; br = 1'b1; end
      default: ;
    endcase
  endtask

  // Called #1 after a rising edge with the DUT idle and OutReady high.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        eb;
    int          elat;
    int          lat;
    model(op, a, b, er, eb, elat);
    chk({tag, "_inready"}, 32'(bus.InReady), 32'd1);
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.Operation = op;
    bus.InValid   = 1'b1;
    @(posedge clk); #1;
    bus.InValid   = 1'b0;
    bus.SrcA      = $urandom;
    bus.SrcB      = $urandom;
    bus.Operation = 4'($urandom);
    lat = 1;
    while (!bus.OutValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_res"}, bus.Result, er);
    chk({tag, "_br"}, 32'(bus.Branch), 32'(eb));
    chk({tag, "_busy"}, 32'(bus.Busy), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_ovlow"}, 32'(bus.OutValid), 32'd0);
    chk({tag, "_hold"}, bus.Result, er);
  endtask

  initial begin
    logic seen;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    bus.Operation = '0;
    bus.InValid   = 1'b0;
    bus.OutReady  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", bus.Result, 32'h0);
    chk("rst_branch", 32'(bus.Branch), 32'd0);
    chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_inready", 32'(bus.InReady), 32'd1);
    rst_n = 1'b1;

    run_op("add_wrap", 4'h2, 32'h7FFF_FFFF, 32'h1);
    chk("add_wrap_abs", bus.Result, 32'h8000_0000);
    run_op("blt", 4'hB, 32'hFFFF_FFFF, 32'h1);
    chk("blt_abs", 32'(bus.Branch), 32'd1);
    run_op("bge", 4'hD, 32'hFFFF_FFFF, 32'h1);
    chk("bge_abs", 32'(bus.Branch), 32'd0);
    run_op("beq", 4'h8, 32'd5, 32'd5);
    run_op("lui_bne", 4'h9, 32'd3, 32'h1234_5000);
    chk("lui_abs", bus.Result, 32'h1234_5000);
    run_op("sra31", 4'h7, 32'h8000_0000, 32'd31);
    chk("sra31_abs", bus.Result, 32'hFFFF_FFFF);
    run_op("srl31", 4'h5, 32'h8000_0000, 32'd31);
    chk("srl31_abs", bus.Result, 32'h0000_0001);
    run_op("sll0", 4'h4, 32'hA5, 32'h20);
    chk("sll0_abs", bus.Result, 32'hA5);
    run_op("jalr", 4'hF, 32'h1001, 32'd4);
    chk("jalr_abs", bus.Result, 32'h1004);
    run_op("unsup", 4'hA, 32'hDEAD_BEEF, 32'h1);

    // Backpressure: result held, pending SUB not taken until OutReady
    bus.OutReady  = 1'b0;
    bus.SrcA      = 32'h1;
    bus.SrcB      = 32'h4;
    bus.Operation = 4'h4;
    bus.InValid   = 1'b1;
    @(posedge clk); #1;
    bus.SrcA      = 32'd100;
    bus.SrcB      = 32'd7;
    bus.Operation = 4'h3;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("bp_first_valid", 32'(bus.OutValid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_res", bus.Result, 32'h10);
      chk("bp_inready", 32'(bus.InReady), 32'd0);
      chk("bp_outvalid", 32'(bus.OutValid), 32'd1);
      @(posedge clk); #1;
    end
    bus.OutReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_inready", 32'(bus.InReady), 32'd1);
    chk("bp_release_ov", 32'(bus.OutValid), 32'd0);
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    chk("bp_sub_valid", 32'(bus.OutValid), 32'd1);
    chk("bp_sub_res", bus.Result, 32'd93);
    @(posedge clk); #1;

    // Randomized ops against the model
    for (int n = 0; n < 80; n++) begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (n % 5 == 0) rb = ra;
      run_op("rand", rop, ra, rb);
    end

    // Reset in the 5th shift cycle of a 20-bit SRL aborts it
    bus.SrcA      = 32'hF0F0_1234;
    bus.SrcB      = 32'd20;
    bus.Operation = 4'h5;
    bus.InValid   = 1'b1;
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", 32'(bus.Busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_inready", 32'(bus.InReady), 32'd1);
    chk("mid_ov", 32'(bus.OutValid), 32'd0);
    chk("mid_res", bus.Result, 32'h0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.OutValid) seen = 1'b1;
    end
    chk("mid_no_ov", 32'(seen), 32'd0);
    chk("mid_res_late", bus.Result, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
